// File: rtl/eth_rx_frame_buffer.sv
// Receive frame buffer: stores frames from the RGMII receiver in a circular RAM and
// releases a frame to the valid/ready byte stream only after it ends with a good CRC.
module eth_rx_frame_buffer #(
    parameter int AWIDTH = 11,
    parameter int CWIDTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    input  logic              in_sop,
    input  logic              in_eop,
    input  logic              in_crc_ok,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sop,
    output logic              out_eop,
    output logic [CWIDTH-1:0] frames_ok,
    output logic [CWIDTH-1:0] frames_dropped
);

    localparam int DEPTH = 2 ** AWIDTH;
    localparam logic [AWIDTH:0] FULL_LEVEL = {1'b1, {AWIDTH{1'b0}}};

    typedef enum logic [1:0] {IDLE, RECV, DISCARD} wr_state_t;

    wr_state_t         state_reg, state_next;
    logic [AWIDTH:0]   wr_ptr_reg, wr_ptr_next;
    logic [AWIDTH:0]   commit_ptr_reg, commit_ptr_next;
    logic [AWIDTH:0]   rd_ptr_reg;
    logic [AWIDTH:0]   fetch_ptr_reg;
    logic [7:0]        pend_reg, pend_next;
    logic [AWIDTH:0]   used;
    logic              full;
    logic              mem_we;
    logic [8:0]        mem_wdata;
    logic              ok_inc, drop_inc;

    // Each entry is {last, data}
    logic [8:0]        mem [DEPTH];
    logic [8:0]        mem_q_reg;
    logic              s1_valid_reg;
    logic              first_reg;
    logic              avail, handshake, s1_move, rd_en;

    // rd_ptr only moves on handshake, so bytes sitting in the read pipeline still occupy space
    assign used = wr_ptr_reg - rd_ptr_reg;
    assign full = (used == FULL_LEVEL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            wr_ptr_reg     <= '0;
            commit_ptr_reg <= '0;
            pend_reg       <= '0;
            frames_ok      <= '0;
            frames_dropped <= '0;
        end else begin
            state_reg      <= state_next;
            wr_ptr_reg     <= wr_ptr_next;
            commit_ptr_reg <= commit_ptr_next;
            pend_reg       <= pend_next;
            frames_ok      <= frames_ok + CWIDTH'(ok_inc);
            frames_dropped <= frames_dropped + CWIDTH'(drop_inc);
        end
    end

    always_comb begin
        state_next      = state_reg;
        wr_ptr_next     = wr_ptr_reg;
        commit_ptr_next = commit_ptr_reg;
        pend_next       = pend_reg;
        mem_we          = 1'b0;
        mem_wdata       = {1'b0, pend_reg};
        ok_inc          = 1'b0;
        drop_inc        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (in_eop) begin
                    drop_inc = 1'b1;
                end else if (in_valid && in_sop) begin
                    pend_next  = in_data;
                    state_next = RECV;
                end
            end
            RECV: begin
                if (in_eop) begin
                    state_next = IDLE;
                    if (in_crc_ok && !full) begin
                        mem_we          = 1'b1;
                        mem_wdata       = {1'b1, pend_reg};
                        wr_ptr_next     = wr_ptr_reg + 1'b1;
                        commit_ptr_next = wr_ptr_reg + 1'b1;
                        ok_inc          = 1'b1;
                    end else begin
                        wr_ptr_next = commit_ptr_reg;
                        drop_inc    = 1'b1;
                    end
                end else if (in_valid && in_sop) begin
                    wr_ptr_next = commit_ptr_reg;
                    drop_inc    = 1'b1;
                    pend_next   = in_data;
                end else if (in_valid) begin
                    if (full) begin
                        wr_ptr_next = commit_ptr_reg;
                        state_next  = DISCARD;
                    end else begin
                        mem_we      = 1'b1;
                        wr_ptr_next = wr_ptr_reg + 1'b1;
                        pend_next   = in_data;
                    end
                end
            end
            DISCARD: begin
                if (in_eop) begin
                    drop_inc   = 1'b1;
                    state_next = IDLE;
                end else if (in_valid && in_sop) begin
                    drop_inc   = 1'b1;
                    pend_next  = in_data;
                    state_next = RECV;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Read pipeline: mem_q_reg is the RAM output stage, out_* is the presentation stage
    assign avail     = (fetch_ptr_reg != commit_ptr_reg);
    assign handshake = out_valid && out_ready;
    assign s1_move   = s1_valid_reg && (!out_valid || out_ready);
    assign rd_en     = avail && (!s1_valid_reg || s1_move);

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr_reg[AWIDTH-1:0]] <= mem_wdata;
        end
        if (rd_en) begin
            mem_q_reg <= mem[fetch_ptr_reg[AWIDTH-1:0]];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_reg    <= '0;
            fetch_ptr_reg <= '0;
            s1_valid_reg  <= 1'b0;
            first_reg     <= 1'b1;
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_sop       <= 1'b0;
            out_eop       <= 1'b0;
        end else begin
            rd_ptr_reg    <= rd_ptr_reg + (AWIDTH+1)'(handshake);
            fetch_ptr_reg <= fetch_ptr_reg + (AWIDTH+1)'(rd_en);
            s1_valid_reg  <= rd_en || (s1_valid_reg && !s1_move);
            if (s1_move) begin
                out_valid <= 1'b1;
                out_data  <= mem_q_reg[7:0];
                out_eop   <= mem_q_reg[8];
                out_sop   <= first_reg;
                first_reg <= mem_q_reg[8];
            end else if (handshake) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_eth_rx_frame_buffer.sv
// Scoreboard bench for eth_rx_frame_buffer using a 64-byte buffer so overflow is reachable.
module tb_eth_rx_frame_buffer;

    localparam int AW = 6;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_sop = 1'b0;
    logic          in_eop = 1'b0;
    logic          in_crc_ok = 1'b0;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_sop;
    logic          out_eop;
    logic [CW-1:0] frames_ok;
    logic [CW-1:0] frames_dropped;

    int tests = 0;
    int fails = 0;
    logic [9:0] exp_q[$];  // {sop, eop, data}

    eth_rx_frame_buffer #(.AWIDTH(AW), .CWIDTH(CW)) dut (
        .clk(clk),
        .reset(reset),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_sop(in_sop),
        .in_eop(in_eop),
        .in_crc_ok(in_crc_ok),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sop(out_sop),
        .out_eop(out_eop),
        .frames_ok(frames_ok),
        .frames_dropped(frames_dropped)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic sop);
        in_valid = 1'b1;
        in_sop   = sop;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        in_sop   = 1'b0;
    endtask

    task automatic send_eop(input logic crc);
        in_eop    = 1'b1;
        in_crc_ok = crc;
        tick();
        in_eop    = 1'b0;
        in_crc_ok = 1'b0;
    endtask

    task automatic send_frame(input int n, input logic [7:0] base, input logic crc, input logic expect_out);
        if (expect_out) begin
            for (int i = 0; i < n; i++)
                exp_q.push_back({(i == 0), (i == n - 1), base + 8'(i)});
        end
        for (int i = 0; i < n; i++)
            send_byte(base + 8'(i), (i == 0));
        send_eop(crc);
        $display("[TB] frame len=%0d base=0x%02h crc_ok=%0d expected_out=%0d", n, base, crc, expect_out);
    endtask

    task automatic wait_drain(input string name);
        int c = 0;
        while (exp_q.size() != 0 && c < 2000) begin
            tick();
            c++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
        repeat (4) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete();
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Monitor: pops the scoreboard on every accepted byte and checks hold-while-stalled
    initial begin : monitor
        logic       stall_prev;
        logic [10:0] held;
        logic [9:0] e;
        stall_prev = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev)
                    check("stall_hold", 32'({out_valid, out_sop, out_eop, out_data}), 32'(held));
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_byte: got data 0x%02h sop %0d eop %0d, expected no output",
                                 out_data, out_sop, out_eop);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_byte", 32'({out_sop, out_eop, out_data}), 32'(e));
                    end
                end
                stall_prev = out_valid && !out_ready;
                held = {out_valid, out_sop, out_eop, out_data};
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int c;
        tick();
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_sop", 32'(out_sop), 32'd0);
        check("reset_out_eop", 32'(out_eop), 32'd0);
        check("reset_out_data", 32'(out_data), 32'd0);
        check("reset_frames_ok", 32'(frames_ok), 32'd0);
        check("reset_frames_dropped", 32'(frames_dropped), 32'd0);
        reset = 1'b0;
        tick();

        // Good 64-byte frame, consumer always ready
        out_ready = 1'b1;
        send_frame(64, 8'h00, 1'b1, 1'b1);
        tick();
        tick();
        check("eop_latency_valid", 32'(out_valid), 32'd1);
        wait_drain("good64_drain");
        check("good64_frames_ok", 32'(frames_ok), 32'd1);
        check("good64_frames_dropped", 32'(frames_dropped), 32'd0);

        // Same frame with bad CRC
        do_reset();
        send_frame(64, 8'h00, 1'b0, 1'b0);
        repeat (10) tick();
        check("badcrc_out_valid", 32'(out_valid), 32'd0);
        check("badcrc_frames_dropped", 32'(frames_dropped), 32'd1);
        check("badcrc_frames_ok", 32'(frames_ok), 32'd0);
        check("badcrc_wr_ptr", 32'(dut.wr_ptr_reg), 32'd0);
        check("badcrc_commit_ptr", 32'(dut.commit_ptr_reg), 32'd0);

        // Overflow: second 40-byte frame cannot fit behind the first
        do_reset();
        out_ready = 1'b0;
        send_frame(40, 8'h40, 1'b1, 1'b1);
        send_frame(40, 8'h80, 1'b1, 1'b0);
        check("ovf_frames_ok", 32'(frames_ok), 32'd1);
        check("ovf_frames_dropped", 32'(frames_dropped), 32'd1);
        out_ready = 1'b1;
        wait_drain("ovf_drain");
        check("ovf_idle_after_drain", 32'(out_valid), 32'd0);

        // New sop in the middle of a frame
        do_reset();
        for (int i = 0; i < 10; i++)
            send_byte(8'hA0 + 8'(i), (i == 0));
        $display("[TB] partial frame len=10 base=0xa0 cut by new sop");
        send_frame(20, 8'h10, 1'b1, 1'b1);
        wait_drain("midsop_drain");
        check("midsop_frames_dropped", 32'(frames_dropped), 32'd1);
        check("midsop_frames_ok", 32'(frames_ok), 32'd1);

        // Three back-to-back frames with a toggling consumer
        do_reset();
        out_ready = 1'b1;
        fork
            begin
                send_frame(5, 8'h20, 1'b1, 1'b1);
                send_frame(17, 8'h30, 1'b1, 1'b1);
                send_frame(30, 8'h50, 1'b1, 1'b1);
            end
            begin
                for (int k = 0; k < 200; k++) begin
                    out_ready = ~out_ready;
                    tick();
                end
            end
        join
        out_ready = 1'b1;
        wait_drain("toggle_drain");
        check("toggle_frames_ok", 32'(frames_ok), 32'd3);
        check("toggle_frames_dropped", 32'(frames_dropped), 32'd0);

        // Reset while a committed frame is being read out
        do_reset();
        out_ready = 1'b1;
        send_frame(30, 8'h60, 1'b1, 1'b1);
        c = 0;
        while (exp_q.size() > 20 && c < 200) begin
            tick();
            c++;
        end
        check("midread_progress", 32'(exp_q.size() <= 20), 32'd1);
        reset = 1'b1;
        exp_q.delete();
        tick();
        check("midread_out_valid", 32'(out_valid), 32'd0);
        check("midread_out_sop", 32'(out_sop), 32'd0);
        check("midread_out_eop", 32'(out_eop), 32'd0);
        check("midread_out_data", 32'(out_data), 32'd0);
        check("midread_frames_ok", 32'(frames_ok), 32'd0);
        check("midread_frames_dropped", 32'(frames_dropped), 32'd0);
        reset = 1'b0;
        tick();
        send_frame(12, 8'hC0, 1'b1, 1'b1);
        wait_drain("after_reset_drain");
        check("after_reset_frames_ok", 32'(frames_ok), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/eth_rx_frame_buffer.md
Name: eth_rx_frame_buffer

Overview:
- Sits directly downstream of eth_rgmii_rx in the rx_clk domain; consumes its byte stream (data/valid/sop/eop/crc_ok).
- Stores each frame in an internal circular buffer and releases it to a downstream valid/ready byte stream only after eop with crc_ok.
- Frames with a bad CRC, overflowed frames, frames cut short by a new sop, and empty frames are discarded by rolling back the write pointer, and counted.

Parameters:
- AWIDTH, 11, buffer address width; depth DEPTH = 2**AWIDTH bytes, one 9-bit entry per byte (8 data + 1 last flag).
- CWIDTH, 16, width of drop and good-frame counters.

Ports:
- clk  input  1  buffer clock; connects to phy0_rxc.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  8  received byte.
- in_valid  input  1  in_data valid this cycle.
- in_sop  input  1  qualifies the first byte of a frame; only meaningful with in_valid.
- in_eop  input  1  single-cycle end-of-frame pulse; never asserted together with in_valid.
- in_crc_ok  input  1  frame CRC good; sampled only when in_eop=1.
- out_data  output  8  byte to consumer.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts the byte when out_valid and out_ready are both 1.
- out_sop  output  1  out_data is the first byte of a frame.
- out_eop  output  1  out_data is the last byte of a frame.
- frames_ok  output  CWIDTH  committed frame count; wraps.
- frames_dropped  output  CWIDTH  discarded frame count; wraps.

Behaviour:
- Pointers: wr_ptr, commit_ptr and rd_ptr are each AWIDTH+1 bits. used = wr_ptr - rd_ptr (modulo arithmetic). Buffer full when used == DEPTH.
- Reset: all pointers 0; write FSM goes to IDLE; pending register empty; out_valid=0, out_sop=0, out_eop=0, out_data=0; both counters 0.
- Write FSM states: IDLE, RECV, DISCARD.
  - IDLE: a byte with in_valid&in_sop stores in_data into the pending register and moves to RECV. A byte with in_valid but no in_sop is ignored. in_eop in IDLE counts as a drop (empty frame).
  - RECV, each in_valid byte: write the previous pending byte to mem[wr_ptr] with last=0, increment wr_ptr, and hold the new byte as pending. If the buffer is full at that write, nothing is written, wr_ptr is restored to commit_ptr, and the FSM moves to DISCARD.
  - RECV, in_eop with in_crc_ok=1 and buffer not full: write the pending byte with last=1, then commit_ptr <= wr_ptr+1 on the same edge; frames_ok+1.
  - RECV, in_eop with in_crc_ok=0, or with the buffer full: wr_ptr <= commit_ptr; frames_dropped+1. Either eop outcome returns the FSM to IDLE.
  - RECV, in_valid&in_sop (new frame without a prior eop): roll back the current frame, frames_dropped+1, and start the new frame with this byte as pending. The FSM stays in RECV.
  - DISCARD: ignore bytes. On in_eop: frames_dropped+1, go to IDLE. On in_valid&in_sop: frames_dropped+1, start the new frame, go to RECV.
- Read side:
  - Data available when rd_ptr != commit_ptr. Uncommitted bytes are never visible downstream.
  - Output register is first-word-fall-through with one registered memory read stage. out_* hold stable while out_valid=1 and out_ready=0.
  - On a handshake, rd_ptr advances and the next committed byte, if any, appears the following cycle. Back-to-back transfers run at 1 byte/cycle while data is available.
  - out_sop=1 on the first byte after reset and on the byte after any byte with out_eop=1. out_eop is the stored last flag.
  - Latency: for an eop accepted on edge N, out_valid is asserted no later than edge N+2 when the output register is empty.
- Simultaneous commit and read are allowed; full is evaluated using the rd_ptr value before the edge.
- A frame larger than DEPTH always ends up in DISCARD and is dropped; the buffer then holds only previously committed frames.
- Reset during RECV or DISCARD discards both the partial frame and all buffered frames.

Test Plan:
- Reset, then a 64-byte frame 0x00..0x3F with crc_ok=1, out_ready=1:
  - out_valid asserted no later than 2 cycles after eop.
  - 64 bytes out in order; out_sop only on 0x00, out_eop only on 0x3F.
  - frames_ok=1.
- Same frame with crc_ok=0: out_valid stays 0; frames_dropped=1; wr_ptr == commit_ptr == 0.
- AWIDTH=6, out_ready=0:
  - 40-byte good frame, then a 40-byte good frame: the second overflows.
  - frames_ok=1, frames_dropped=1.
  - Then out_ready=1: exactly 40 bytes drain and the last one has out_eop=1.
- sop mid-frame: 10 bytes, then a new sop with a 20-byte good frame: frames_dropped=1, frames_ok=1, only the 20 bytes are output.
- out_ready toggled 1/0 every cycle across 3 back-to-back good frames:
  - Byte order and sop/eop flags preserved.
  - out_data stable while stalled.
- Assert reset mid-way through the read of a committed frame: all outputs and counters return to 0; a following good frame is output intact starting with out_sop=1.
